// File: rtl/gac.sv
// gac: get-action stage, directly downstream of the match/lookup stage.
//
// Buffers metadata (MD) and PHV in two 256-deep first-word-fall-through
// FIFOs. For each packet it reads a 32-bit action word from an internal
// action table, using the 13-bit match index in MD[63:51] with its valid
// bit in MD[50]. It writes the action into MD, retargets MD to the next
// module and forwards MD+PHV downstream. The action table and the
// counters are reachable over the localbus.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_gac_md / _wr          MD from the upstream stage and its write strobe
//   out_gac_md_alf           MD almost-full to upstream
//   in_gac_phv / _wr         PHV from the upstream stage and its write strobe
//   out_gac_phv_alf          PHV almost-full to upstream
//   out_gac_md / _wr         MD to the next module and its write strobe
//   in_gac_md_alf            downstream MD almost-full
//   out_gac_phv / _wr        PHV to the next module and its write strobe
//   in_gac_phv_alf           downstream PHV almost-full
//   cfg2gac_cs_n             localbus chip select (active low)
//   gac2cfg_ack_n            localbus acknowledge (active low)
//   cfg2gac_rw               0 = write, 1 = read
//   cfg2gac_addr             byte address; word offset is addr[9:2]
//   cfg2gac_wdata            write data
//   gac2cfg_rdata            read data
//
// Localbus handshake: the master drives rw/addr/wdata and pulls cs_n low,
// holding all of them stable. After synchronisation the block performs the
// access, then drives ack_n low and keeps rdata stable until it sees the
// synchronised cs_n go high again, at which point ack_n returns high.
//
// Register map (word offsets):
//   0 status  [31:30] datapath state, [3:0] = {out_md_alf, out_phv_alf,
//             in_md_alf, in_phv_alf}
//   1 in_md_count   2 out_md_count   3 hit_count   4 miss_count
//   5 table address (R/W, [AW-1:0])  6 table data (R/W at table[addr reg])
//   other offsets read 0 and ignore writes.
module gac #(
  parameter logic [7:0] LMID = 8'd4,
  parameter logic [7:0] NMID = 8'd5,
  parameter int         AW   = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [255:0]  in_gac_md,
  input  logic          in_gac_md_wr,
  output logic          out_gac_md_alf,
  input  logic [1023:0] in_gac_phv,
  input  logic          in_gac_phv_wr,
  output logic          out_gac_phv_alf,
  output logic [255:0]  out_gac_md,
  output logic          out_gac_md_wr,
  input  logic          in_gac_md_alf,
  output logic [1023:0] out_gac_phv,
  output logic          out_gac_phv_wr,
  input  logic          in_gac_phv_alf,
  input  logic          cfg2gac_cs_n,
  output logic          gac2cfg_ack_n,
  input  logic          cfg2gac_rw,
  input  logic [31:0]   cfg2gac_addr,
  input  logic [31:0]   cfg2gac_wdata,
  output logic [31:0]   gac2cfg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOK = 2'd1,
    S_OUT  = 2'd2
  } dp_state_t;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_WRITE = 3'd1,
    C_READ  = 3'd2,
    C_WAIT  = 3'd3,
    C_ACK   = 3'd4
  } cfg_state_t;

  // ---------------------------------------------------------------- FIFOs
  logic [255:0]  md_mem  [0:255];
  logic [1023:0] phv_mem [0:255];
  logic [7:0]    md_wp, md_rp, phv_wp, phv_rp;
  logic [8:0]    md_cnt, phv_cnt;
  logic          md_push, phv_push;
  logic          accept;
  logic [255:0]  md_head;
  logic [1023:0] phv_head;

  // Writes into a full FIFO are silently dropped.
  assign md_push  = in_gac_md_wr  && (md_cnt  != 9'd256);
  assign phv_push = in_gac_phv_wr && (phv_cnt != 9'd256);

  // First-word-fall-through: the head entry is visible without a pop.
  assign md_head  = md_mem[md_rp];
  assign phv_head = phv_mem[phv_rp];

  assign out_gac_md_alf  = in_gac_md_alf  || (md_cnt  > 9'd250);
  assign out_gac_phv_alf = in_gac_phv_alf || (phv_cnt > 9'd250);

  always_ff @(posedge clk) begin
    if (md_push)  md_mem[md_wp]   <= in_gac_md;
    if (phv_push) phv_mem[phv_wp] <= in_gac_phv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_wp   <= 8'd0;
      md_rp   <= 8'd0;
      md_cnt  <= 9'd0;
      phv_wp  <= 8'd0;
      phv_rp  <= 8'd0;
      phv_cnt <= 9'd0;
    end else begin
      if (md_push)  md_wp  <= md_wp + 8'd1;
      if (accept)   md_rp  <= md_rp + 8'd1;
      if (phv_push) phv_wp <= phv_wp + 8'd1;
      if (accept)   phv_rp <= phv_rp + 8'd1;
      case ({md_push, accept})
        2'b10:   md_cnt <= md_cnt + 9'd1;
        2'b01:   md_cnt <= md_cnt - 9'd1;
        default: md_cnt <= md_cnt;
      endcase
      case ({phv_push, accept})
        2'b10:   phv_cnt <= phv_cnt + 9'd1;
        2'b01:   phv_cnt <= phv_cnt - 9'd1;
        default: phv_cnt <= phv_cnt;
      endcase
    end
  end

  // --------------------------------------------------------- action table
  cfg_state_t    c_state, c_next;
  logic [AW-1:0] addr_reg;
  logic [7:0]    reg_off;
  logic          tbl_we;
  logic [31:0]   tbl [0:(1<<AW)-1];
  logic [31:0]   a_q;   // port A: datapath read data
  logic [31:0]   b_q;   // port B: localbus read data

  assign reg_off = cfg2gac_addr[9:2];
  assign tbl_we  = (c_state == C_WRITE) && (reg_off == 8'd6);

  // Both ports sample the array before the write lands, so a same-cycle
  // read of the address being written returns the old word.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[addr_reg] <= cfg2gac_wdata;
    if (accept) a_q <= tbl[md_head[51 +: AW]];
    b_q <= tbl[addr_reg];
  end

  // ------------------------------------------------------- datapath FSM
  dp_state_t     dp_state, dp_next;
  logic [255:0]  md_lat;
  logic [1023:0] phv_lat;
  logic [255:0]  md_proc;
  logic          is_hit, is_miss;
  logic [31:0]   in_md_count, out_md_count, hit_count, miss_count;

  always_comb begin
    dp_next = dp_state;
    accept  = 1'b0;
    case (dp_state)
      S_IDLE: begin
        if ((md_cnt != 9'd0) && (phv_cnt != 9'd0) &&
            !in_gac_md_alf && !in_gac_phv_alf) begin
          accept  = 1'b1;
          dp_next = S_LOOK;
        end
      end
      S_LOOK:  dp_next = S_OUT;
      S_OUT:   dp_next = S_IDLE;
      default: dp_next = S_IDLE;
    endcase
  end

  // Rewrite of the latched MD; a_q holds the table word during LOOK.
  always_comb begin
    md_proc = md_lat;
    is_hit  = 1'b0;
    is_miss = 1'b0;
    if (md_lat[87:80] == LMID) begin
      md_proc[87:80] = NMID;
      if (md_lat[50]) begin
        md_proc[159:128] = a_q;
        md_proc[50]      = 1'b0;
        is_hit           = 1'b1;
      end else begin
        md_proc[159:128] = 32'd0;
        is_miss          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_state       <= S_IDLE;
      md_lat         <= '0;
      phv_lat        <= '0;
      out_gac_md     <= '0;
      out_gac_phv    <= '0;
      out_gac_md_wr  <= 1'b0;
      out_gac_phv_wr <= 1'b0;
      in_md_count    <= 32'd0;
      out_md_count   <= 32'd0;
      hit_count      <= 32'd0;
      miss_count     <= 32'd0;
    end else begin
      dp_state <= dp_next;
      if (accept) begin
        md_lat  <= md_head;
        phv_lat <= phv_head;
      end
      // Outputs are loaded at the end of LOOK so both strobes are high
      // for the single OUT cycle.
      if (dp_state == S_LOOK) begin
        out_gac_md     <= md_proc;
        out_gac_phv    <= phv_lat;
        out_gac_md_wr  <= 1'b1;
        out_gac_phv_wr <= 1'b1;
        out_md_count   <= out_md_count + 32'd1;
        if (is_hit)  hit_count  <= hit_count + 32'd1;
        if (is_miss) miss_count <= miss_count + 32'd1;
      end else begin
        out_gac_md_wr  <= 1'b0;
        out_gac_phv_wr <= 1'b0;
      end
      if (md_push) in_md_count <= in_md_count + 32'd1;
    end
  end

  // ------------------------------------------------------------ localbus
  logic        cs_s1, cs_s2;
  logic [31:0] reg_rd;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{cfg2gac_addr[31:10], cfg2gac_addr[1:0]};

  assign status = {dp_state, 26'd0, out_gac_md_alf, out_gac_phv_alf,
                   in_gac_md_alf, in_gac_phv_alf};

  always_comb begin
    reg_rd = 32'd0;
    case (reg_off)
      8'd0:    reg_rd = status;
      8'd1:    reg_rd = in_md_count;
      8'd2:    reg_rd = out_md_count;
      8'd3:    reg_rd = hit_count;
      8'd4:    reg_rd = miss_count;
      8'd5:    reg_rd = {{(32-AW){1'b0}}, addr_reg};
      8'd6:    reg_rd = b_q;
      default: reg_rd = 32'd0;
    endcase
  end

  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE:  if (cs_s2) c_next = cfg2gac_rw ? C_READ : C_WRITE;
      C_WRITE: c_next = C_WAIT;
      C_READ:  c_next = C_WAIT;
      C_WAIT:  c_next = C_ACK;
      C_ACK:   if (!cs_s2) c_next = C_IDLE;
      default: c_next = C_IDLE;
    endcase
  end

  assign gac2cfg_ack_n = (c_state != C_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1         <= 1'b0;
      cs_s2         <= 1'b0;
      c_state       <= C_IDLE;
      addr_reg      <= '0;
      gac2cfg_rdata <= 32'd0;
    end else begin
      cs_s1   <= ~cfg2gac_cs_n;
      cs_s2   <= cs_s1;
      c_state <= c_next;
      if ((c_state == C_WRITE) && (reg_off == 8'd5))
        addr_reg <= cfg2gac_wdata[AW-1:0];
      if (c_state == C_READ)
        gac2cfg_rdata <= reg_rd;
    end
  end

endmodule

// File: tb/tb_gac.sv
module tb_gac;

  localparam logic [7:0] LMID = 8'd4;
  localparam logic [7:0] NMID = 8'd5;

  logic          clk, rst;
  logic [255:0]  in_gac_md;
  logic          in_gac_md_wr;
  logic          out_gac_md_alf;
  logic [1023:0] in_gac_phv;
  logic          in_gac_phv_wr;
  logic          out_gac_phv_alf;
  logic [255:0]  out_gac_md;
  logic          out_gac_md_wr;
  logic          in_gac_md_alf;
  logic [1023:0] out_gac_phv;
  logic          out_gac_phv_wr;
  logic          in_gac_phv_alf;
  logic          cfg2gac_cs_n;
  logic          gac2cfg_ack_n;
  logic          cfg2gac_rw;
  logic [31:0]   cfg2gac_addr;
  logic [31:0]   cfg2gac_wdata;
  logic [31:0]   gac2cfg_rdata;

  gac #(.LMID(LMID), .NMID(NMID), .AW(13)) dut (
    .clk(clk), .rst(rst),
    .in_gac_md(in_gac_md), .in_gac_md_wr(in_gac_md_wr),
    .out_gac_md_alf(out_gac_md_alf),
    .in_gac_phv(in_gac_phv), .in_gac_phv_wr(in_gac_phv_wr),
    .out_gac_phv_alf(out_gac_phv_alf),
    .out_gac_md(out_gac_md), .out_gac_md_wr(out_gac_md_wr),
    .in_gac_md_alf(in_gac_md_alf),
    .out_gac_phv(out_gac_phv), .out_gac_phv_wr(out_gac_phv_wr),
    .in_gac_phv_alf(in_gac_phv_alf),
    .cfg2gac_cs_n(cfg2gac_cs_n), .gac2cfg_ack_n(gac2cfg_ack_n),
    .cfg2gac_rw(cfg2gac_rw), .cfg2gac_addr(cfg2gac_addr),
    .cfg2gac_wdata(cfg2gac_wdata), .gac2cfg_rdata(gac2cfg_rdata)
  );

  // ------------------------------------------------ clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------ scoreboard state
  int n_cmp  = 0;
  int n_fail = 0;
  logic [255:0]  exp_q[$];
  logic [1023:0] exp_phv_q[$];
  logic [31:0]   tbl_m [int];
  int m_hit = 0, m_miss = 0, m_in = 0, m_out = 0;
  bit hold_no_out   = 1'b0;
  bit check_spacing = 1'b0;
  int last_out_cyc  = -1;

  function automatic logic [255:0] rand_md();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Output monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [255:0]  em;
    logic [1023:0] ep;
    if (!rst && (out_gac_md_wr || out_gac_phv_wr)) begin
      n_cmp++;
      if (out_gac_md_wr !== out_gac_phv_wr) begin
        n_fail++;
        $display("FAIL wr_pair: md_wr=%b phv_wr=%b expected equal", out_gac_md_wr, out_gac_phv_wr);
      end
      n_cmp++;
      if (hold_no_out) begin
        n_fail++;
        $display("FAIL hold_output: output strobe seen while downstream alf held, expected none");
      end
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: md=%h with empty expected queue", out_gac_md);
      end else begin
        em = exp_q.pop_front();
        ep = exp_phv_q.pop_front();
        n_cmp++;
        if (out_gac_md !== em) begin
          n_fail++;
          $display("FAIL out_md: got %h expected %h", out_gac_md, em);
        end
        n_cmp++;
        if (out_gac_phv !== ep) begin
          n_fail++;
          $display("FAIL out_phv: got %h expected %h", out_gac_phv, ep);
        end
      end
      if (check_spacing) begin
        if (last_out_cyc >= 0) begin
          n_cmp++;
          if (cyc - last_out_cyc != 3) begin
            n_fail++;
            $display("FAIL out_spacing: got %0d cycles expected 3", cyc - last_out_cyc);
          end
        end
        last_out_cyc = cyc;
      end
    end
  end

  // ------------------------------------------------ driver tasks
  task automatic push_pkt(input logic [255:0] md, input logic [1023:0] phv);
    logic [255:0] e;
    int idx;
    e = md;
    idx = int'(md[63:51]);
    if (md[87:80] == LMID) begin
      e[87:80] = NMID;
      if (md[50]) begin
        e[159:128] = tbl_m.exists(idx) ? tbl_m[idx] : 32'hxxxxxxxx;
        e[50] = 1'b0;
        m_hit++;
      end else begin
        e[159:128] = 32'd0;
        m_miss++;
      end
    end
    exp_q.push_back(e);
    exp_phv_q.push_back(phv);
    m_in++;
    m_out++;
    in_gac_md     = md;
    in_gac_phv    = phv;
    in_gac_md_wr  = 1'b1;
    in_gac_phv_wr = 1'b1;
    @(posedge clk);
    #1;
    in_gac_md_wr  = 1'b0;
    in_gac_phv_wr = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] off, input logic [31:0] d);
    int t;
    cfg2gac_rw    = 1'b0;
    cfg2gac_addr  = {22'd0, off, 2'b00};
    cfg2gac_wdata = d;
    cfg2gac_cs_n  = 1'b0;
    t = 0;
    while (gac2cfg_ack_n !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (gac2cfg_ack_n !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_write_ack: off=%0d ack_n=%b expected 0 within 40 cycles", off, gac2cfg_ack_n);
    end
    @(posedge clk);
    #1 cfg2gac_cs_n = 1'b1;
    t = 0;
    while (gac2cfg_ack_n !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (gac2cfg_ack_n !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_write_release: ack_n=%b expected 1 within 40 cycles", gac2cfg_ack_n);
    end
  endtask

  task automatic cfg_read(input logic [7:0] off, output logic [31:0] d);
    int t;
    cfg2gac_rw   = 1'b1;
    cfg2gac_addr = {22'd0, off, 2'b00};
    cfg2gac_cs_n = 1'b0;
    t = 0;
    while (gac2cfg_ack_n !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (gac2cfg_ack_n !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_read_ack: off=%0d ack_n=%b expected 0 within 40 cycles", off, gac2cfg_ack_n);
    end
    d = gac2cfg_rdata;
    @(posedge clk);
    #1 cfg2gac_cs_n = 1'b1;
    t = 0;
    while (gac2cfg_ack_n !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (gac2cfg_ack_n !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_read_release: ack_n=%b expected 1 within 40 cycles", gac2cfg_ack_n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d packets outstanding expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    logic [31:0] v;
    cfg_read(8'd1, v);
    n_cmp++;
    if (v !== 32'(m_in)) begin n_fail++; $display("FAIL %s in_md_count: got %0d expected %0d", tag, v, m_in); end
    cfg_read(8'd2, v);
    n_cmp++;
    if (v !== 32'(m_out)) begin n_fail++; $display("FAIL %s out_md_count: got %0d expected %0d", tag, v, m_out); end
    cfg_read(8'd3, v);
    n_cmp++;
    if (v !== 32'(m_hit)) begin n_fail++; $display("FAIL %s hit_count: got %0d expected %0d", tag, v, m_hit); end
    cfg_read(8'd4, v);
    n_cmp++;
    if (v !== 32'(m_miss)) begin n_fail++; $display("FAIL %s miss_count: got %0d expected %0d", tag, v, m_miss); end
  endtask

  // ------------------------------------------------ scenarios
  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_gac_md_wr, out_gac_phv_wr, out_gac_md_alf, out_gac_phv_alf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000",
               {out_gac_md_wr, out_gac_phv_wr, out_gac_md_alf, out_gac_phv_alf});
    end
    n_cmp++;
    if (out_gac_md !== 256'd0) begin n_fail++; $display("FAIL reset_out_md: got %h expected 0", out_gac_md); end
    n_cmp++;
    if (out_gac_phv !== 1024'd0) begin n_fail++; $display("FAIL reset_out_phv: nonzero expected 0"); end
    n_cmp++;
    if (gac2cfg_ack_n !== 1'b1) begin n_fail++; $display("FAIL reset_ack_n: got %b expected 1", gac2cfg_ack_n); end
    n_cmp++;
    if (gac2cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", gac2cfg_rdata); end
    @(posedge clk);
    #1 rst = 1'b0;
    check_counters("reset");
    cfg_read(8'd0, v);
    n_cmp++;
    if (v[3:0] !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %h expected low nibble 0", v); end
  endtask

  task automatic test_pass_through();
    logic [255:0] md;
    md = rand_md();
    md[87:80] = 8'd7;
    push_pkt(md, 1024'hA5);
    // Accept cycle is the one right after the write edge; strobes are
    // high only in the cycle following the second edge after it.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_gac_md_wr !== (k == 2) || out_gac_phv_wr !== (k == 2)) begin
        n_fail++;
        $display("FAIL pass_timing: cycle %0d md_wr=%b phv_wr=%b expected %b",
                 k, out_gac_md_wr, out_gac_phv_wr, (k == 2));
      end
    end
    wait_drain(20);
    check_counters("pass");
  endtask

  task automatic test_hit();
    logic [255:0] md;
    cfg_write(8'd5, 32'h12);
    cfg_write(8'd6, 32'hDEADBEEF);
    tbl_m[32'h12] = 32'hDEADBEEF;
    md = rand_md();
    md[87:80] = LMID;
    md[63:51] = 13'h12;
    md[50] = 1'b1;
    push_pkt(md, rand_phv());
    wait_drain(20);
    check_counters("hit");
  endtask

  task automatic test_miss();
    logic [255:0] md;
    md = rand_md();
    md[87:80] = LMID;
    md[50] = 1'b0;
    md[159:128] = 32'hFFFFFFFF;
    push_pkt(md, rand_phv());
    wait_drain(20);
    check_counters("miss");
  endtask

  task automatic test_cfg_readback();
    logic [31:0] v;
    int t;
    cfg_write(8'd5, 32'h1FFF);
    cfg_write(8'd6, 32'h0000CAFE);
    tbl_m[32'h1FFF] = 32'h0000CAFE;
    cfg2gac_rw   = 1'b1;
    cfg2gac_addr = {22'd0, 8'd6, 2'b00};
    cfg2gac_cs_n = 1'b0;
    t = 0;
    while (gac2cfg_ack_n !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (gac2cfg_rdata !== 32'h0000CAFE || gac2cfg_ack_n !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_rd6: rdata=%h ack_n=%b expected 0000cafe/0", gac2cfg_rdata, gac2cfg_ack_n);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (gac2cfg_ack_n !== 1'b0 || gac2cfg_rdata !== 32'h0000CAFE) begin
        n_fail++;
        $display("FAIL cfg_ack_hold: cycle %0d ack_n=%b rdata=%h expected 0/0000cafe", k, gac2cfg_ack_n, gac2cfg_rdata);
      end
    end
    cfg2gac_cs_n = 1'b1;
    t = 0;
    while (gac2cfg_ack_n !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (gac2cfg_ack_n !== 1'b1) begin n_fail++; $display("FAIL cfg_ack_release: ack_n=%b expected 1", gac2cfg_ack_n); end
    cfg_read(8'h20, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL cfg_unmapped: got %h expected 0", v); end
    cfg_read(8'd5, v);
    n_cmp++;
    if (v !== 32'h1FFF) begin n_fail++; $display("FAIL cfg_addr_reg: got %h expected 1fff", v); end
  endtask

  task automatic test_random();
    logic [255:0] md;
    logic [12:0]  idx_l [4];
    logic [31:0]  d;
    int kind;
    for (int i = 0; i < 4; i++) begin
      idx_l[i] = 13'($urandom_range(0, 8191));
      d = $urandom();
      cfg_write(8'd5, {19'd0, idx_l[i]});
      cfg_write(8'd6, d);
      tbl_m[int'(idx_l[i])] = d;
    end
    for (int n = 0; n < 40; n++) begin
      md = rand_md();
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        if (md[87:80] == LMID) md[87:80] = 8'd9;
      end else if (kind == 2) begin
        md[87:80] = LMID;
        md[50] = 1'b0;
      end else begin
        md[87:80] = LMID;
        md[50] = 1'b1;
        md[63:51] = idx_l[$urandom_range(0, 3)];
      end
      push_pkt(md, rand_phv());
      if ($urandom_range(0, 5) == 0) begin
        in_gac_phv_alf = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 in_gac_phv_alf = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain(400);
    check_counters("random");
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    in_gac_md_alf = 1'b1;
    hold_no_out = 1'b1;
    for (int i = 0; i < 252; i++) begin
      push_pkt(rand_md(), rand_phv());
      n_cmp++;
      if (out_gac_phv_alf !== (i + 1 > 250) || out_gac_md_alf !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_alf: after %0d pushes md_alf=%b phv_alf=%b expected 1/%b",
                 i + 1, out_gac_md_alf, out_gac_phv_alf, (i + 1 > 250));
      end
    end
    cfg_read(8'd0, v);
    n_cmp++;
    if (v[3:0] !== 4'b1110) begin n_fail++; $display("FAIL bp_status: got %h expected low nibble e", v); end
    repeat (5) @(negedge clk);
    hold_no_out = 1'b0;
    check_spacing = 1'b1;
    last_out_cyc = -1;
    @(posedge clk);
    #1 in_gac_md_alf = 1'b0;
    wait_drain(252 * 3 + 50);
    check_spacing = 1'b0;
    n_cmp++;
    if (out_gac_md_alf !== 1'b0 || out_gac_phv_alf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_alf_clear: md_alf=%b phv_alf=%b expected 0/0", out_gac_md_alf, out_gac_phv_alf);
    end
    check_counters("backpressure");
  endtask

  task automatic test_reset_mid();
    logic [255:0] md;
    logic [31:0]  v;
    md = rand_md();
    md[87:80] = LMID;
    md[63:51] = 13'h12;
    md[50] = 1'b1;
    push_pkt(md, rand_phv());      // accepted in the next cycle
    push_pkt(rand_md(), rand_phv()); // left waiting in the FIFOs
    // First packet is now in its lookup cycle.
    rst = 1'b1;
    exp_q.delete();
    exp_phv_q.delete();
    m_hit = 0; m_miss = 0; m_in = 0; m_out = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_gac_md_wr, out_gac_phv_wr, out_gac_md_alf, out_gac_phv_alf, gac2cfg_ack_n} !== 5'b00001) begin
        n_fail++;
        $display("FAIL rstmid_outputs: got %b expected 00001",
                 {out_gac_md_wr, out_gac_phv_wr, out_gac_md_alf, out_gac_phv_alf, gac2cfg_ack_n});
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_gac_md_wr !== 1'b0 || out_gac_phv_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_no_out: cycle %0d md_wr=%b phv_wr=%b expected 0/0", k, out_gac_md_wr, out_gac_phv_wr);
      end
    end
    check_counters("rstmid");
    cfg_write(8'd5, 32'h12);
    cfg_read(8'd6, v);
    n_cmp++;
    if (v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rstmid_table: got %h expected deadbeef", v); end
    md = rand_md();
    md[87:80] = 8'd1;
    push_pkt(md, rand_phv());
    wait_drain(20);
  endtask

  // ------------------------------------------------ main sequence
  initial begin
    rst            = 1'b1;
    in_gac_md      = '0;
    in_gac_md_wr   = 1'b0;
    in_gac_phv     = '0;
    in_gac_phv_wr  = 1'b0;
    in_gac_md_alf  = 1'b0;
    in_gac_phv_alf = 1'b0;
    cfg2gac_cs_n   = 1'b1;
    cfg2gac_rw     = 1'b0;
    cfg2gac_addr   = 32'd0;
    cfg2gac_wdata  = 32'd0;

    test_reset();
    test_pass_through();
    test_hit();
    test_miss();
    test_cfg_readback();
    test_random();
    test_backpressure();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
